div64_host_seq: RTL and testbench
=================================

Name: div64_host_seq

Overview:
Upstream host-side sequencer for the 64-bit divide coprocessor. Accepts a 64-bit dividend/divisor pair on a valid/ready interface and serializes it as four 32-bit words on the coprocessor word bus with a phase/sequence tag. Waits for the coprocessor to reach its write-back state, then reads back four result words and presents quotient and remainder on a valid/ready result interface. Replaces the software word-pumping loop; divide-by-zero is trapped locally and a watchdog guards against a hung coprocessor.

Parameters:
WORD_HOLD, 2, cycles each outbound word/tag is held stable (min 1)
RD_LAT, 2, cycles from driving a read tag to sampling from_cop (min 1)
TIMEOUT_CYCLES, 1024, max cycles in WAIT before abort (min 1)
COP_WB_STATE, 3'd5, coprocessor state code meaning results ready

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
op_valid  in  1  operand pair valid
op_ready  out  1  sequencer can accept operands (high only in IDLE)
op_a  in  64  dividend
op_b  in  64  divisor
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
res_quot  out  64  quotient
res_rem  out  64  remainder
res_dz  out  1  divide-by-zero (valid with res_valid)
res_to  out  1  coprocessor timeout (valid with res_valid)
to_cop  out  32  outbound data word
tag_cop  out  7  {phase[2:0], enable, seq[2:0]}
from_cop  in  32  inbound result word
stat_cop  in  7  {cop_state[2:0], cop_cnt[3:0]}
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0 (op_ready=0 during reset, rises 1 cycle after reset deasserts); state IDLE; operand/result regs cleared; counters 0. Reset in any state aborts immediately with no result; tag_cop returns to 0.
- States: IDLE, SEND, WAIT, READ, DONE.
- IDLE: op_ready=1, tag_cop=0. On op_valid: latch op_a/op_b. If op_b==0 -> DONE with res_quot=64'hFFFF_FFFF_FFFF_FFFF, res_rem=op_a, res_dz=1; coprocessor untouched. Otherwise -> SEND, word index 0.
- SEND: phase=3'd1, enable=1. Words in order: seq0 A[31:0], seq1 A[63:32], seq2 B[31:0], seq3 B[63:32]. Each word/tag is held exactly WORD_HOLD cycles, so SEND lasts 4*WORD_HOLD cycles. Then -> WAIT, watchdog cleared.
- WAIT: phase=3'd3, enable=0, seq=0, to_cop=0. Watchdog increments each cycle. When stat_cop[6:4]==COP_WB_STATE -> READ. If the watchdog reaches TIMEOUT_CYCLES first -> DONE with quot=rem=0, res_to=1. The watchdog check takes priority over a WB indication arriving in the same cycle.
- READ: phase=3'd5, enable=1. Seq order is 3,2,1,0, capturing rem[31:0], rem[63:32], quot[31:0], quot[63:32] respectively. Each seq is driven for RD_LAT cycles; from_cop is sampled on the last of them. After seq0 -> DONE.
- DONE: tag_cop=0, res_valid=1, outputs stable. Transfer occurs when res_valid&&res_ready; then -> IDLE with res_valid, res_dz, res_to cleared next cycle. res_ready held low stalls indefinitely with outputs unchanged.
- op_valid outside IDLE is ignored; op_ready=0 there.
- Latency for a nonzero divisor, op accept to res_valid: 1 + 4*WORD_HOLD + WAIT cycles + 4*RD_LAT.
- All counters are sized by $clog2 of their parameter and saturate rather than wrap.

Decomposition:
- Shared package div64_pkg: state encoding, phase codes (PH_IDLE=0, PH_LOAD=1, PH_GO=3, PH_READ=5), COP_WB_STATE default, tag field positions.
- One sub-module: seq_hold_ctr, a loadable down-counter with a done pulse. It is instantiated for WORD_HOLD, RD_LAT and the watchdog.

Test Plan:
- a=100, b=7, WORD_HOLD=2, RD_LAT=2, behavioural coprocessor model -> tag seq 0..3 each held 2 cycles; res_quot=14, res_rem=2; res_dz=0, res_to=0.
- a=64'hFFFF_FFFF_FFFF_FFFF, b=1 -> quot=all ones, rem=0; verify high/low word ordering on to_cop and on read-back.
- a=123, b=0 -> no SEND (tag_cop stays 0), res_valid 1 cycle after accept; quot=all ones, rem=123, res_dz=1.
- Coprocessor never reports COP_WB_STATE, TIMEOUT_CYCLES=16 -> res_to=1 exactly 16 WAIT cycles after entry; quot=rem=0; next op accepted normally.
- res_ready low for 10 cycles in DONE -> outputs stable, op_ready=0; release -> IDLE next cycle, back-to-back op accepted.
- reset asserted during SEND word 2 -> next cycle IDLE, tag_cop=0, res_valid=0; fresh op 50/5 gives quot=10, rem=0.

Source files
------------

// File: rtl/div64_host_seq_pkg.sv
// div64_pkg: shared state encoding, phase codes and tag/status layout for the divide host sequencer
package div64_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_READ, ST_DONE} state_t;
   localparam logic [2:0] PH_IDLE = 3'd0;
   localparam logic [2:0] PH_LOAD = 3'd1;
   localparam logic [2:0] PH_GO = 3'd3;
   localparam logic [2:0] PH_READ = 3'd5;
   localparam logic [2:0] COP_WB_DEFAULT = 3'd5;
   localparam int STAT_ST_LSB = 4;
   function automatic logic [6:0] mk_tag(input logic [2:0] ph, input logic en, input logic [1:0] seq);
      return {ph, en, 1'b0, seq};
   endfunction
endpackage

// File: rtl/div64_host_seq_if.sv
// div64_host_seq_if: operand/result handshakes plus the coprocessor word bus
interface div64_host_seq_if;
   logic op_valid, op_ready;
   logic [63:0] op_a, op_b;
   logic res_valid, res_ready;
   logic [63:0] res_quot, res_rem;
   logic res_dz, res_to;
   logic [31:0] to_cop, from_cop;
   logic [6:0] tag_cop, stat_cop;
   logic busy;
   modport slave (
      input op_valid, op_a, op_b, res_ready, from_cop, stat_cop,
      output op_ready, res_valid, res_quot, res_rem, res_dz, res_to, to_cop, tag_cop, busy
   );
   modport master (
      output op_valid, op_a, op_b, res_ready, from_cop, stat_cop,
      input op_ready, res_valid, res_quot, res_rem, res_dz, res_to, to_cop, tag_cop, busy
   );
endinterface

// File: rtl/div64_host_seq_seq_hold_ctr.sv
// seq_hold_ctr: reloadable saturating down-counter; o_done flags the final enabled cycle of a hold
module seq_hold_ctr #(
   parameter int MAX = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_load,
   input  logic i_en,
   output logic o_done
);
   localparam int W = MAX > 1 ? $clog2(MAX) : 1;
   localparam logic [W-1:0] RELOAD = W'(MAX - 1);
   logic [W-1:0] r_cnt;
   // Load restarts a hold of MAX cycles; counting stops at zero instead of wrapping
   always_ff @(posedge clk) begin
      if (reset) r_cnt <= '0;
      else if (i_load) r_cnt <= RELOAD;
      else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
   end
   assign o_done = i_en && r_cnt == '0;
endmodule

// File: rtl/div64_host_seq.sv
// div64_host_seq: serializes a 64-bit divide onto the coprocessor word bus and collects the result
module div64_host_seq
   import div64_pkg::*;
#(
   parameter int WORD_HOLD = 2,
   parameter int RD_LAT = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter logic [2:0] COP_WB_STATE = COP_WB_DEFAULT
) (
   input logic clk,
   input logic reset,
   div64_host_seq_if.slave bus
);
   state_t r_state, w_next;
   logic r_live, r_dz, r_to;
   logic [63:0] r_a, r_b, r_quot, r_rem;
   logic [1:0] r_idx;
   logic w_accept, w_bz, w_wb, w_last_word, w_en;
   logic w_hold_done, w_rd_done, w_wd_done;
   logic [2:0] w_phase;
   logic [31:0] w_word;
   logic [5:0] w_half;
   logic w_unused;

   assign w_bz = bus.op_b == '0;
   assign w_accept = bus.op_ready && bus.op_valid;
   assign w_wb = bus.stat_cop[STAT_ST_LSB +: 3] == COP_WB_STATE;
   assign w_last_word = r_idx == 2'd3;
   assign w_half = r_idx[0] ? 6'd0 : 6'd32;
   assign w_unused = ^bus.stat_cop[3:0];

   seq_hold_ctr #(.MAX(WORD_HOLD)) u_hold (
      .clk(clk), .reset(reset),
      .i_load((w_accept && !w_bz) || (r_state == ST_SEND && w_hold_done && !w_last_word)),
      .i_en(r_state == ST_SEND), .o_done(w_hold_done)
   );
   seq_hold_ctr #(.MAX(TIMEOUT_CYCLES)) u_wdog (
      .clk(clk), .reset(reset),
      .i_load(r_state == ST_SEND && w_hold_done && w_last_word),
      .i_en(r_state == ST_WAIT), .o_done(w_wd_done)
   );
   seq_hold_ctr #(.MAX(RD_LAT)) u_rd (
      .clk(clk), .reset(reset),
      .i_load((r_state == ST_WAIT && !w_wd_done && w_wb) || (r_state == ST_READ && w_rd_done && r_idx != 2'd0)),
      .i_en(r_state == ST_READ), .o_done(w_rd_done)
   );

   // State register
   always_ff @(posedge clk) r_state <= reset ? ST_IDLE : w_next;

   // Next state: watchdog expiry wins over a write-back indication in the same cycle
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_next = w_bz ? ST_DONE : ST_SEND;
         ST_SEND: if (w_hold_done && w_last_word) w_next = ST_WAIT;
         ST_WAIT: if (w_wd_done) w_next = ST_DONE; else if (w_wb) w_next = ST_READ;
         ST_READ: if (w_rd_done && r_idx == 2'd0) w_next = ST_DONE;
         ST_DONE: if (bus.res_ready) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Moore outputs: tag/word bus and handshake flags decoded from the state
   always_comb begin
      w_phase = r_state == ST_SEND ? PH_LOAD : r_state == ST_WAIT ? PH_GO : r_state == ST_READ ? PH_READ : PH_IDLE;
      w_en = r_state inside {ST_SEND, ST_READ};
      w_word = r_idx[1] ? (r_idx[0] ? r_b[63:32] : r_b[31:0]) : (r_idx[0] ? r_a[63:32] : r_a[31:0]);
      bus.tag_cop = mk_tag(w_phase, w_en, w_en ? r_idx : 2'd0);
      bus.to_cop = r_state == ST_SEND ? w_word : '0;
      bus.op_ready = r_state == ST_IDLE && r_live;
      bus.res_valid = r_state == ST_DONE;
      bus.busy = r_state != ST_IDLE;
   end

   assign bus.res_quot = r_quot;
   assign bus.res_rem = r_rem;
   assign bus.res_dz = r_dz;
   assign bus.res_to = r_to;

   // Operand latch, word index walk (up in SEND, down in READ), result capture and status flags
   always_ff @(posedge clk) begin
      if (reset) begin
         r_live <= 1'b0;
         r_a <= '0;
         r_b <= '0;
         r_quot <= '0;
         r_rem <= '0;
         r_idx <= 2'd0;
         r_dz <= 1'b0;
         r_to <= 1'b0;
      end else begin
         r_live <= 1'b1;
         if (w_accept) begin
            r_a <= bus.op_a;
            r_b <= bus.op_b;
            r_idx <= 2'd0;
            r_dz <= w_bz;
            r_to <= 1'b0;
            r_quot <= w_bz ? '1 : '0;
            r_rem <= w_bz ? bus.op_a : '0;
         end
         if (r_state == ST_SEND && w_hold_done && !w_last_word) r_idx <= r_idx + 2'd1;
         if (r_state == ST_WAIT && w_wd_done) r_to <= 1'b1;
         if (r_state == ST_READ && w_rd_done) begin
            if (r_idx[1]) r_rem[w_half +: 32] <= bus.from_cop;
            else r_quot[w_half +: 32] <= bus.from_cop;
            if (r_idx != 2'd0) r_idx <= r_idx - 2'd1;
         end
         if (bus.res_valid && bus.res_ready) begin
            r_dz <= 1'b0;
            r_to <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_div64_host_seq.sv
// tb_div64_host_seq: directed and random divides against a behavioural coprocessor and divide reference
module tb_div64_host_seq;
   localparam int WH = 2;
   localparam int RL = 2;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_tests = 0;
   int n_fail = 0;

   div64_host_seq_if bus ();
   div64_host_seq #(.WORD_HOLD(WH), .RD_LAT(RL), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // Coprocessor model: collects the four words, raises write-back after cop_dly WAIT cycles, answers reads one cycle late
   logic [31:0] cap [4];
   logic [6:0] send_log [$];
   int seen = 0;
   int wait_cnt = 0;
   bit cop_wb = 1'b0;
   int cop_dly = 1;

   function automatic logic [31:0] cop_word(input logic [1:0] s);
      logic [63:0] a, b, q, r;
      a = {cap[1], cap[0]};
      b = {cap[3], cap[2]};
      q = b == 0 ? '1 : a / b;
      r = b == 0 ? a : a % b;
      return s == 2'd3 ? r[31:0] : s == 2'd2 ? r[63:32] : s == 2'd1 ? q[31:0] : q[63:32];
   endfunction

   always @(posedge clk) begin
      if (bus.tag_cop[6:3] == 4'b0011) begin
         cap[bus.tag_cop[1:0]] <= bus.to_cop;
         send_log.push_back(bus.tag_cop);
      end
      if (bus.tag_cop[6:4] == 3'd3) begin
         seen <= seen + 1;
         wait_cnt <= wait_cnt + 1;
         bus.stat_cop <= (cop_wb && seen + 1 >= cop_dly) ? 7'h50 : 7'h00;
      end else begin
         seen <= 0;
         bus.stat_cop <= 7'h00;
      end
      bus.from_cop <= bus.tag_cop[6:3] == 4'b1011 ? cop_word(bus.tag_cop[1:0]) : 32'h0;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input logic [63:0] a, input logic [63:0] b, input bit wb, input int dly, input int stall);
      logic [63:0] eq, er;
      logic edz, eto;
      int ewait, elat, lat, lbase, wbase;
      logic ok;
      if (b == 0) begin
         eq = '1; er = a; edz = 1; eto = 0; ewait = 0; elat = 1;
      end else if (!wb || dly + 1 >= TO) begin
         eq = 0; er = 0; edz = 0; eto = 1; ewait = TO; elat = 1 + 4 * WH + TO;
      end else begin
         eq = a / b; er = a % b; edz = 0; eto = 0; ewait = dly + 1; elat = 1 + 4 * WH + ewait + 4 * RL;
      end
      cop_wb = wb;
      cop_dly = dly;
      lbase = send_log.size();
      wbase = wait_cnt;
      chk("idle_ready", bus.op_ready, 1);
      bus.op_a = a;
      bus.op_b = b;
      bus.op_valid = 1'b1;
      @(negedge clk);
      bus.op_a = ~a;
      bus.op_b = 64'd0;
      lat = 1;
      while (!bus.res_valid && lat < 4000) begin
         @(negedge clk);
         lat++;
      end
      bus.op_valid = 1'b0;
      chk("res_valid", bus.res_valid, 1);
      chk("latency", 64'(lat), 64'(elat));
      chk("quot", bus.res_quot, eq);
      chk("rem", bus.res_rem, er);
      chk("dz", bus.res_dz, edz);
      chk("to", bus.res_to, eto);
      chk("wait_cycles", 64'(wait_cnt - wbase), 64'(ewait));
      ok = 1'b1;
      if (send_log.size() - lbase != (b == 0 ? 0 : 4 * WH)) ok = 1'b0;
      else for (int i = 0; i < send_log.size() - lbase; i++)
         if (send_log[lbase + i] != {3'd1, 1'b1, 3'(i / WH)}) ok = 1'b0;
      chk("send_seq", ok, 1);
      if (b != 0) begin
         chk("words_a", {cap[1], cap[0]}, a);
         chk("words_b", {cap[3], cap[2]}, b);
      end
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         chk("stall_quot", bus.res_quot, eq);
         chk("stall_valid_rdy", {bus.res_valid, bus.op_ready}, 2'b10);
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      chk("after_valid", bus.res_valid, 0);
      chk("after_flags", {bus.res_dz, bus.res_to, bus.busy}, 3'b000);
      chk("after_ready", bus.op_ready, 1);
   endtask

   initial begin
      int n;
      logic [63:0] ra, rb;
      bus.op_valid = 1'b0;
      bus.op_a = '0;
      bus.op_b = '0;
      bus.res_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", bus.op_ready, 0);
      chk("rst_valid_busy", {bus.res_valid, bus.busy, bus.res_dz, bus.res_to}, 4'b0000);
      chk("rst_tag", bus.tag_cop, 0);
      chk("rst_to_cop", bus.to_cop, 0);
      chk("rst_quot", bus.res_quot, 0);
      chk("rst_rem", bus.res_rem, 0);
      reset = 1'b0;
      chk("ready_lag", bus.op_ready, 0);
      @(negedge clk);
      do_op(64'd100, 64'd7, 1, 3, 0);
      do_op('1, 64'd1, 1, 5, 0);
      do_op(64'd123, 64'd0, 1, 3, 0);
      do_op(64'd77, 64'd5, 0, 1, 0);
      do_op(64'd9, 64'd4, 1, 2, 0);
      do_op(64'd1000, 64'd33, 1, 14, 0);
      do_op(64'd1000, 64'd33, 1, 15, 0);
      do_op(64'h0123_4567_89AB_CDEF, 64'h0000_0001_0000_0003, 1, 4, 10);
      do_op(64'd555, 64'd10, 1, 1, 0);
      cop_wb = 1;
      cop_dly = 3;
      bus.op_a = 64'd1000;
      bus.op_b = 64'd3;
      bus.op_valid = 1'b1;
      @(negedge clk);
      bus.op_valid = 1'b0;
      n = 0;
      while (bus.tag_cop != 7'b0011_010 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("reach_word2", bus.tag_cop, 7'b0011_010);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_tag", bus.tag_cop, 0);
      chk("abort_valid_busy", {bus.res_valid, bus.busy}, 2'b00);
      chk("abort_ready_lag", bus.op_ready, 0);
      @(negedge clk);
      do_op(64'd50, 64'd5, 1, 4, 0);
      for (int k = 0; k < 8; k++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom} >> $urandom_range(0, 63);
         do_op(ra, rb == 0 ? 64'd1 : rb, 1, $urandom_range(1, 14), $urandom_range(0, 3));
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
